mem_access_unit: RTL and testbench

- Sits between the multi-cycle control FSM/datapath and the unified instruction/data memory.
- Turns the FSM's single-cycle memory strobes (adr_src, ir_write, mem_write) into a req/ack bus transaction with wait-state support.
- Holds the non-architectural instruction register, old-PC register and data register.
- Asserts stall back to the FSM until each access completes.

---
 rtl/riscv_mem_pkg.sv | 52 +++++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory access unit: FSM states, funct3 size codes, strobes, NOP.
// Also holds the lane-offset and misalignment helpers used by the datapath and the FSM.
package riscv_mem_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_DONE = 3'd2;
   localparam logic [2:0] ST_ERR  = 3'd3;
   localparam logic [2:0] ST_MIS  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      DONE = ST_DONE,
      ERR  = ST_ERR,
      MIS  = ST_MIS
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // funct3[1:0] alone carries the access size; funct3[2] selects zero-extension
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         SZ_B:    lane_offset = off;
         SZ_H:    lane_offset = {off[1], 1'b0};
         default: lane_offset = 2'b00;
      endcase
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         SZ_B:    addr_misaligned = 1'b0;
         SZ_H:    addr_misaligned = off[0];
         default: addr_misaligned = |off;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store data shift + strobes, load lane select + sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_strb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [1:0]  st_lane;
   logic [1:0]  ld_lane;
   logic [31:0] ld_shift;
   logic        ld_signed;

   always_comb begin
      st_lane  = lane_offset(st_funct3, st_off);
      st_strb  = STRB_W;
      st_wdata = st_data;
      case (st_funct3[1:0])
         SZ_B: begin
            st_strb  = STRB_B << st_lane;
            st_wdata = {24'b0, st_data[7:0]} << {st_lane, 3'b000};
         end
         SZ_H: begin
            st_strb  = STRB_H << st_lane;
            st_wdata = {16'b0, st_data[15:0]} << {st_lane, 3'b000};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_lane   = lane_offset(ld_funct3, ld_off);
      ld_shift  = ld_rdata >> {ld_lane, 3'b000};
      ld_signed = ~ld_funct3[2];
      ld_data   = ld_rdata;
      case (ld_funct3[1:0])
         SZ_B:    ld_data = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
         SZ_H:    ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Converts FSM memory strobes to a req/ack bus access; holds instr, old_pc, data. MISALIGN_TRAP_EN adds a misaligned trap.
// Latency: IDLE + REQ (1 + wait states) + DONE; stall low on DONE, so at least 3 cycles per access.
// Backpressure: stall held to the FSM until ack or timeout (TIMEOUT_CYCLES REQ cycles -> bus_err pulse).
module mem_access_unit
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  access_valid,
   input  logic                  adr_src,
   input  logic                  ir_write,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [ADDR_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] old_pc,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  stall,
`ifdef MISALIGN_TRAP_EN
   output logic                  misaligned,
`endif
   output logic                  bus_err
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [1:0]              low_q, low_d;
   logic                    mem_we_q, mem_we_d;
   logic [3:0]              mem_wstrb_q, mem_wstrb_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic                    ir_write_q, ir_write_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [31:0]             instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]   old_pc_q, old_pc_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic [ADDR_WIDTH-1:0]   acc_addr;
   logic [31:0]             st_wdata;
   logic [3:0]              st_strb;
   logic [31:0]             ld_data;

   assign acc_addr = adr_src ? alu_result : pc;

   // Store path works on live IDLE inputs; load path on the latched size/offset and bus data.
   mem_lane_align u_align (
      .st_funct3 (funct3),
      .st_off    (acc_addr[1:0]),
      .st_data   (write_data),
      .st_wdata  (st_wdata),
      .st_strb   (st_strb),
      .ld_funct3 (funct3_q),
      .ld_off    (low_q),
      .ld_rdata  (mem_rdata),
      .ld_data   (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_addr_d  = mem_addr_q;
      low_d       = low_q;
      mem_we_d    = mem_we_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;
      ir_write_d  = ir_write_q;
      funct3_d    = funct3_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      old_pc_d    = old_pc_q;
      data_d      = data_q;
      stall       = 1'b0;

      case (state_q)
         IDLE: begin
            stall = access_valid;
            if (access_valid) begin
               mem_addr_d  = {acc_addr[ADDR_WIDTH-1:2], 2'b00};
               low_d       = acc_addr[1:0];
               mem_we_d    = mem_write & adr_src;
               mem_wstrb_d = (mem_write & adr_src) ? st_strb : STRB_NONE;
               mem_wdata_d = st_wdata;
               ir_write_d  = ir_write;
               funct3_d    = funct3;
               pc_d        = pc;
               cnt_d       = '0;
               state_d     = REQ;
`ifdef MISALIGN_TRAP_EN
               if (adr_src && !ir_write && addr_misaligned(funct3, acc_addr[1:0])) begin
                  state_d = MIS;
               end
`endif
            end
         end

         REQ: begin
            stall = 1'b1;
            if (mem_ack) begin
               cnt_d   = '0;
               state_d = DONE;
               if (ir_write_q) begin
                  instr_d  = mem_rdata;
                  old_pc_d = pc_q;
               end else if (!mem_we_q) begin
                  data_d = ld_data;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Timed-out fetch leaves a NOP so the FSM never executes stale bits
               cnt_d   = '0;
               state_d = ERR;
               if (ir_write_q) begin
                  instr_d = NOP_INSTR;
               end else begin
                  data_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         low_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_wstrb_q <= STRB_NONE;
         mem_wdata_q <= '0;
         ir_write_q  <= 1'b0;
         funct3_q    <= F3_W;
         pc_q        <= '0;
         instr_q     <= NOP_INSTR;
         old_pc_q    <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         low_q       <= low_d;
         mem_we_q    <= mem_we_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
         ir_write_q  <= ir_write_d;
         funct3_q    <= funct3_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         old_pc_q    <= old_pc_d;
         data_q      <= data_d;
      end
   end

   // Decoded from the async-reset state so mem_req drops the moment rst_n falls
   assign mem_req   = (state_q == REQ);
   assign bus_err   = (state_q == ERR);
`ifdef MISALIGN_TRAP_EN
   assign misaligned = (state_q == MIS);
`endif
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign instr     = instr_q;
   assign old_pc    = old_pc_q;
   assign data      = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized accesses against a byte-arithmetic reference model of the unit.
module tb_mem_access_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        access_valid, adr_src, ir_write, mem_write;
   logic [2:0]  funct3;
   logic [31:0] pc, alu_result, write_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] instr, old_pc, data;
   logic        stall, bus_err;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   int tests = 0;
   int fails = 0;
   logic [31:0] m_instr, m_old_pc, m_data;
   logic [2:0]  ld_tab [5];

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .access_valid (access_valid),
      .adr_src      (adr_src),
      .ir_write     (ir_write),
      .mem_write    (mem_write),
      .funct3       (funct3),
      .pc           (pc),
      .alu_result   (alu_result),
      .write_data   (write_data),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .old_pc       (old_pc),
      .data         (data),
      .stall        (stall),
`ifdef MISALIGN_TRAP_EN
      .misaligned   (misaligned),
`endif
      .bus_err      (bus_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Effective byte offset: low bits beyond the access size are dropped
   function automatic int eoff(input logic [2:0] f3, input logic [31:0] a);
      int o;
      o = int'(a[1:0]);
      return o - (o % sz(f3));
   endfunction

   function automatic logic [31:0] lmask(input int s);
      logic [63:0] m;
      m = (64'd1 << (8 * s)) - 64'd1;
      return m[31:0];
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      int s;
      s = sz(f3);
      v = (rd >> (8 * eoff(f3, a))) & lmask(s);
      if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~lmask(s);
      return v;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
      int st;
      st = ((1 << sz(f3)) - 1) << eoff(f3, a);
      return st[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] wd);
      logic [63:0] t;
      t = 64'(wd & lmask(sz(f3))) << (8 * eoff(f3, a));
      return t[31:0];
   endfunction

   // kind: 0 fetch, 1 load, 2 store
   task automatic access(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
      int nstall;
      @(posedge clk); #1;
      access_valid = 1'b1;
      adr_src      = (kind != 0);
      ir_write     = (kind == 0);
      mem_write    = (kind == 2);
      funct3       = f3;
      write_data   = wd;
      if (kind == 0) begin
         pc = addr; alu_result = $urandom;
      end else begin
         alu_result = addr; pc = $urandom;
      end
      #1;
      nstall = stall ? 1 : 0;
      chk("idle_no_req", mem_req, 1'b0);
      for (int i = 0; i <= waits; i++) begin
         @(posedge clk); #1;
         if (stall) nstall++;
         if (i == 0) begin
            chk("req", mem_req, 1'b1);
            chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("we", mem_we, (kind == 2));
            chk("strb", mem_wstrb, (kind == 2) ? exp_strb(f3, addr) : 4'b0000);
            if (kind == 2) chk("wdata", mem_wdata, exp_wdata(f3, addr, wd));
         end
         // Inputs are don't-care once REQ is entered
         access_valid = 1'($urandom);
         adr_src      = 1'($urandom);
         ir_write     = 1'($urandom);
         mem_write    = 1'($urandom);
         funct3       = 3'($urandom);
         pc           = $urandom;
         alu_result   = $urandom;
         write_data   = $urandom;
         mem_ack      = (i == waits);
         mem_rdata    = (i == waits) ? rd : $urandom;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; access_valid = 1'b0; ir_write = 1'b0; mem_write = 1'b0; adr_src = 1'b0;
      if (kind == 0) begin
         m_instr = rd; m_old_pc = addr;
      end else if (kind == 1) begin
         m_data = exp_load(f3, addr, rd);
      end
      chk("done_stall", stall, 1'b0);
      chk("done_req", mem_req, 1'b0);
      chk("stall_cycles", nstall, waits + 2);
      chk("instr", instr, m_instr);
      chk("old_pc", old_pc, m_old_pc);
      chk("data", data, m_data);
   endtask

   initial begin
      int reqc;
      bit seen;
      int kind;
      logic [31:0] a;
      logic [2:0]  f3;

      ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      access_valid = 0; adr_src = 0; ir_write = 0; mem_write = 0; funct3 = 0;
      pc = 0; alu_result = 0; write_data = 0; mem_ack = 0; mem_rdata = 0;
      m_instr = NOP; m_old_pc = 0; m_data = 0;

      #12;
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_strb", mem_wstrb, 4'b0000);
      chk("rst_stall", stall, 1'b0);
      chk("rst_buserr", bus_err, 1'b0);
      chk("rst_instr", instr, NOP);
      chk("rst_oldpc", old_pc, 32'h0);
      chk("rst_data", data, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      access(0, 32'h0000_0010, 3'b010, 32'h0, 32'h0050_0093, 2);
      chk("fetch_instr_const", instr, 32'h0050_0093);
      access(1, 32'h0000_0103, 3'b000, 32'h0, 32'h80FF_FFFF, 0);
      chk("lb_const", data, 32'hFFFF_FF80);
      access(1, 32'h0000_0103, 3'b100, 32'h0, 32'h80FF_FFFF, 1);
      chk("lbu_const", data, 32'h0000_0080);
      access(2, 32'h0000_0202, 3'b001, 32'h0000_BEEF, 32'h0, 0);

      // Ack while idle must not touch the registers
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("idle_ack_instr", instr, m_instr);
      chk("idle_ack_data", data, m_data);
      chk("idle_ack_req", mem_req, 1'b0);

      // Fetch with no ack: timeout
      @(posedge clk); #1;
      access_valid = 1'b1; adr_src = 1'b0; ir_write = 1'b1; mem_write = 1'b0; pc = 32'h40;
      reqc = 0; seen = 0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(posedge clk); #1;
         if (bus_err) seen = 1;
         else if (mem_req) reqc++;
      end
      access_valid = 1'b0; ir_write = 1'b0;
      m_instr = NOP;
      chk("to_seen", seen, 1'b1);
      chk("to_req_cycles", reqc, 255);
      chk("to_stall", stall, 1'b0);
      chk("to_instr", instr, NOP);
      @(posedge clk); #1;
      chk("to_pulse", bus_err, 1'b0);
      access(0, 32'h0000_0044, 3'b010, 32'h0, 32'h1234_5678, 0);

      // Reset while in REQ
      @(posedge clk); #1;
      access_valid = 1'b1; adr_src = 1'b0; ir_write = 1'b1; pc = 32'h80;
      @(posedge clk); #1;
      access_valid = 1'b0; ir_write = 1'b0;
      chk("pre_rst_req", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      m_instr = NOP; m_old_pc = 0; m_data = 0;
      chk("rst_mid_req", mem_req, 1'b0);
      chk("rst_mid_instr", instr, NOP);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_stall", stall, 1'b0);
      chk("post_rst_req", mem_req, 1'b0);

`ifdef MISALIGN_TRAP_EN
      @(posedge clk); #1;
      access_valid = 1'b1; adr_src = 1'b1; ir_write = 1'b0; mem_write = 1'b0;
      funct3 = 3'b010; alu_result = 32'h101;
      @(posedge clk); #1;
      access_valid = 1'b0;
      chk("mis_pulse", misaligned, 1'b1);
      chk("mis_req", mem_req, 1'b0);
      chk("mis_stall", stall, 1'b0);
      chk("mis_data", data, m_data);
      @(posedge clk); #1;
      chk("mis_pulse_end", misaligned, 1'b0);
      chk("mis_req_end", mem_req, 1'b0);
`else
      access(1, 32'h0000_0101, 3'b010, 32'h0, 32'hCAFE_F00D, 0);
      chk("lw_unaligned_const", data, 32'hCAFE_F00D);
`endif

      for (int n = 0; n < 25; n++) begin
         kind = $urandom_range(0, 2);
         a = $urandom;
         if (kind == 0) begin
            f3 = 3'b010;
            a = a & 32'hFFFF_FFFC;
         end else if (kind == 1) begin
            f3 = ld_tab[$urandom_range(0, 4)];
         end else begin
            f3 = 3'($urandom_range(0, 2));
         end
`ifdef MISALIGN_TRAP_EN
         a = a & ~(32'(sz(f3)) - 32'd1);
`endif
         access(kind, a, f3, $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
